// File: rtl/lcd_bus_if.sv
`timescale 1ns/1ps
// lcd_bus_if: requester handshake and LCD display bus bundled for lcd_bus_arb.
// The arbiter uses the slave modport; the requester/bench side uses master.
interface lcd_bus_if;
    logic       req0;
    logic       req1;
    logic       rs0;
    logic       rs1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (
        output req0, req1, rs0, rs1, data0, data1,
        input  gnt0, gnt1, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  req0, req1, rs0, rs1, data0, data1,
        output gnt0, gnt1, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_bus_arb.sv
`timescale 1ns/1ps
// lcd_bus_arb: two-requester arbiter producing timed write strobes on an HD44780-style LCD bus.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module lcd_bus_arb #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 40,
    parameter int T_LONG  = 1600
) (
    input  logic     clk,
    input  logic     reset,
    lcd_bus_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // Each state loads its duration minus one and leaves when the counter reaches zero.
    localparam logic [15:0] LD_SETUP = 16'(T_SETUP - 1);
    localparam logic [15:0] LD_PULSE = 16'(T_PULSE - 1);
    localparam logic [15:0] LD_HOLD  = 16'(T_HOLD - 1);
    localparam logic [15:0] LD_SHORT = 16'(T_SHORT - 1);
    localparam logic [15:0] LD_LONG  = 16'(T_LONG - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        cnt_done;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        gnt0_nxt;
    logic        gnt1_nxt;
    logic        e_q;
    logic        busy_q;
    logic        rs_q;
    logic        rs_nxt;
    logic [7:0]  data_q;
    logic [7:0]  data_nxt;
    logic        pick1;
    logic        long_cmd;
`ifndef LCD_ARB_FIXED_PRIO_EN
    logic        last1;
    logic        last1_nxt;
`endif

    assign cnt_done = (cnt == 16'd0);

    // Clear display and return home need the long post-write wait.
    assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    // pick1 selects requester 1; a lone requester always wins.
    always_comb begin
`ifdef LCD_ARB_FIXED_PRIO_EN
        pick1 = !bus.req0;
`else
        pick1 = bus.req1 && (!bus.req0 || !last1);
`endif
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        rs_nxt    = rs_q;
        data_nxt  = data_q;
`ifndef LCD_ARB_FIXED_PRIO_EN
        last1_nxt = last1;
`endif
        case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = LD_SETUP;
                    gnt0_nxt  = !pick1;
                    gnt1_nxt  = pick1;
                    rs_nxt    = pick1 ? bus.rs1 : bus.rs0;
                    data_nxt  = pick1 ? bus.data1 : bus.data0;
`ifndef LCD_ARB_FIXED_PRIO_EN
                    last1_nxt = pick1;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = LD_PULSE;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_PULSE: begin
                if (cnt_done) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = LD_HOLD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = long_cmd ? LD_LONG : LD_SHORT;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so E and BUSY switch on the same edge as the FSM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= 16'd0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
`ifndef LCD_ARB_FIXED_PRIO_EN
            last1  <= 1'b1;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gnt0_q <= gnt0_nxt;
            gnt1_q <= gnt1_nxt;
            e_q    <= (state_nxt == S_PULSE);
            busy_q <= (state_nxt != S_IDLE);
            rs_q   <= rs_nxt;
            data_q <= data_nxt;
`ifndef LCD_ARB_FIXED_PRIO_EN
            last1  <= last1_nxt;
`endif
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.busy     = busy_q;
    assign bus.lcd_e    = e_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = data_q;

endmodule

// File: tb/tb_lcd_bus_arb.sv
`timescale 1ns/1ps
// tb_lcd_bus_arb: directed and randomized checks of lcd_bus_arb against a write-timeline model.
// The model tracks each accepted write as a capture edge plus fixed offsets for GNT, E and BUSY.
module tb_lcd_bus_arb;
    localparam int TS  = 2;
    localparam int TP  = 4;
    localparam int TH  = 2;
    localparam int TSH = 40;
    localparam int TL  = 1600;

    logic clk = 1'b0;
    logic reset;

    lcd_bus_if bus ();

    lcd_bus_arb #(
        .T_SETUP(TS),
        .T_PULSE(TP),
        .T_HOLD (TH),
        .T_SHORT(TSH),
        .T_LONG (TL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model: the most recent accepted write.
    bit         m_active = 1'b0;
    int         m_cap    = 0;
    int         m_len    = 0;
    bit         m_win    = 1'b0;
    bit         m_last   = 1'b1;
    bit         m_rs     = 1'b0;
    logic [7:0] m_data   = 8'h00;

    // Observations of the DUT, used by directed steps.
    int cnt_busy, cnt_e, cnt_g0, cnt_g1, cnt_rs_e;
    int first_e_edge, g1_edge, idle_edge;
    bit prev_busy = 1'b0;
    bit auto_drop = 1'b1;
    int order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long(input bit rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    function automatic logic [7:0] rand_data();
        if ($urandom_range(7, 0) == 0) return 8'($urandom_range(4, 0));
        return 8'($urandom);
    endfunction

    task automatic clear_counters();
        cnt_busy     = 0;
        cnt_e        = 0;
        cnt_g0       = 0;
        cnt_g1       = 0;
        cnt_rs_e     = 0;
        first_e_edge = -1;
        g1_edge      = -1;
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare every output.
    task automatic tick();
        bit         r, q0, q1, s0, s1, w;
        logic [7:0] d0, d1;
        int         d;
        r  = reset;
        q0 = bus.req0;
        q1 = bus.req1;
        s0 = bus.rs0;
        s1 = bus.rs1;
        d0 = bus.data0;
        d1 = bus.data1;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_active = 1'b0;
            m_rs     = 1'b0;
            m_data   = 8'h00;
            m_last   = 1'b1;
        end else if ((!m_active || edge_n > m_cap + m_len) && (q0 || q1)) begin
            if (q0 && q1) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = !m_last;
`endif
            end else begin
                w = q1;
            end
            m_active = 1'b1;
            m_cap    = edge_n;
            m_win    = w;
            m_last   = w;
            m_rs     = w ? s1 : s0;
            m_data   = w ? d1 : d0;
            m_len    = TS + TP + TH + (is_long(m_rs, m_data) ? TL : TSH);
        end
        #1;
        d = edge_n - m_cap;
        check("busy",     32'(bus.busy),   32'(m_active && d < m_len));
        check("gnt0",     32'(bus.gnt0),   32'(m_active && d == 0 && !m_win));
        check("gnt1",     32'(bus.gnt1),   32'(m_active && d == 0 && m_win));
        check("lcd_e",    32'(bus.lcd_e),  32'(m_active && d >= TS && d < TS + TP));
        check("lcd_rs",   32'(bus.lcd_rs), 32'(m_rs));
        check("lcd_data", 32'(bus.lcd_data), 32'(m_data));
        check("lcd_rw",   32'(bus.lcd_rw), 32'd0);
        check("gnt_excl", 32'(bus.gnt0 && bus.gnt1), 32'd0);
        if (bus.busy === 1'b1) cnt_busy++;
        if (bus.lcd_e === 1'b1) begin
            cnt_e++;
            if (first_e_edge < 0) first_e_edge = edge_n;
            if (bus.lcd_rs === 1'b1) cnt_rs_e++;
        end
        if (bus.gnt0 === 1'b1) begin
            cnt_g0++;
            order.push_back(0);
            if (auto_drop) bus.req0 = 1'b0;
        end
        if (bus.gnt1 === 1'b1) begin
            cnt_g1++;
            g1_edge = edge_n;
            order.push_back(1);
            if (auto_drop) bus.req1 = 1'b0;
        end
        if (prev_busy && bus.busy === 1'b0) idle_edge = edge_n;
        prev_busy = (bus.busy === 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 4000), 32'd1);
    endtask

    initial begin
        int c0;
        int n;
        reset     = 1'b1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.rs0   = 1'b0;
        bus.rs1   = 1'b0;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        clear_counters();

        // Reset values, with a request held during reset.
        bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h99;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.lcd_data), 32'h00);
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        bus.req0 = 1'b0;
        reset = 1'b0;
        tick();
        tick();

        // Single character write.
        clear_counters();
        bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h41;
        tick();
        c0 = edge_n;
        check("w41_gnt0", 32'(bus.gnt0), 32'd1);
        wait_idle("w41");
        check("w41_busy_len", 32'(cnt_busy), 32'd48);
        check("w41_e_len",    32'(cnt_e), 32'd4);
        check("w41_e_start",  32'(first_e_edge - c0), 32'd2);
        check("w41_gnt_len",  32'(cnt_g0), 32'd1);
        check("w41_rs_hold",  32'(bus.lcd_rs), 32'd1);
        check("w41_data_hold", 32'(bus.lcd_data), 32'h41);

        // Clear display from requester 1.
        clear_counters();
        bus.req1 = 1'b1; bus.rs1 = 1'b0; bus.data1 = 8'h01;
        tick();
        check("clr_gnt1", 32'(bus.gnt1), 32'd1);
        wait_idle("clr");
        check("clr_busy_len", 32'(cnt_busy), 32'd1608);
        check("clr_rs_in_e",  32'(cnt_rs_e), 32'd0);
        check("clr_e_len",    32'(cnt_e), 32'd4);

        // Commands just outside the long-wait set.
        clear_counters();
        bus.req0 = 1'b1; bus.rs0 = 1'b0; bus.data0 = 8'h00;
        tick();
        wait_idle("cmd00");
        check("cmd00_busy_len", 32'(cnt_busy), 32'd48);
        clear_counters();
        bus.req0 = 1'b1; bus.rs0 = 1'b0; bus.data0 = 8'h04;
        tick();
        wait_idle("cmd04");
        check("cmd04_busy_len", 32'(cnt_busy), 32'd48);

        // Late request from requester 1 while busy.
        clear_counters();
        bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h30;
        for (int i = 0; i < 6; i++) tick();
        bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h42;
        n = 0;
        while (cnt_g1 == 0 && n < 200) begin
            tick();
            n++;
        end
        check("late_timeout", 32'(n < 200), 32'd1);
        check("late_gap", 32'(g1_edge - idle_edge), 32'd1);
        wait_idle("late");

        // Reset while the strobe is high.
        clear_counters();
        bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h5A;
        n = 0;
        while (bus.lcd_e !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("pulse_timeout", 32'(n < 20), 32'd1);
        bus.req0 = 1'b1; bus.data0 = 8'h66;
        reset = 1'b1;
        tick();
        check("midrst_e",    32'(bus.lcd_e), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.lcd_data), 32'h00);
        reset = 1'b0;
        tick();
        check("postrst_gnt0", 32'(bus.gnt0), 32'd1);
        check("postrst_data", 32'(bus.lcd_data), 32'h66);
        wait_idle("postrst");

        // Contention with both requests held from reset.
        auto_drop = 1'b0;
        reset = 1'b1;
        bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h10;
        bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h20;
        tick();
        reset = 1'b0;
        order.delete();
        n = 0;
        while (order.size() < 3 && n < 400) begin
            tick();
            n++;
        end
        check("cont_timeout", 32'(n < 400), 32'd1);
        check("cont_first",  32'(order[0]), 32'd0);
`ifdef LCD_ARB_FIXED_PRIO_EN
        check("cont_second", 32'(order[1]), 32'd0);
`else
        check("cont_second", 32'(order[1]), 32'd1);
`endif
        check("cont_third",  32'(order[2]), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        auto_drop = 1'b1;
        wait_idle("cont");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!bus.req0 && $urandom_range(3, 0) == 0) begin
                bus.req0  = 1'b1;
                bus.rs0   = 1'($urandom);
                bus.data0 = rand_data();
            end
            if (!bus.req1 && $urandom_range(3, 0) == 0) begin
                bus.req1  = 1'b1;
                bus.rs1   = 1'($urandom);
                bus.data1 = rand_data();
            end
            reset = ($urandom_range(399, 0) == 0);
            tick();
        end
        reset = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        wait_idle("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
